spi_mem_wb_master: RTL
======================

SPI_MEM_WB_MASTER -- requirements
Module: spi_mem_wb_master

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 24, giving the byte-address width of the memory map.
REQ-002 SHALL have parameter ADDR_BYTES, default 3, giving the address bytes sent on SPI; legal values are 2, 3 and 4.
REQ-003 SHALL have parameter CLOCK_DIVIDER, default 4, giving the clock cycles per SCK period; it is even and at least 2.
REQ-004 SHALL have parameter CS_IDLE_CYCLES, default 2, giving the minimum cycles spi_ss stays high between SPI frames.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clock  in  1  system clock; every flop is rising-edge, and there is no derived-clock logic.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 address  in  ADDRESS_WIDTH-2  Wishbone word address.
REQ-009 wr_data  in  32  write data.
REQ-010 wb_sel  in  4  byte-lane select.
REQ-011 wb_we  in  1  write enable.
REQ-012 wb_cyc  in  1  request.
REQ-013 rd_data  out  32  read data.
REQ-014 wb_ack  out  1  single-cycle acknowledge.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 spi_miso  in  1  serial input; spi_sck, spi_ss, spi_mosi  out  1 each  serial clock, active-low select, serial output.

Function
REQ-017 States SHALL be IDLE, WREN, GAP, FRAME and DONE.
REQ-018 A request starts in IDLE when wb_cyc=1 and the CS_IDLE_CYCLES counter has expired; address, wr_data, wb_sel and wb_we are captured in that cycle.
REQ-019 Lane decode: first = lowest set bit of wb_sel; last = highest set bit; N = last-first+1.
REQ-020 Non-contiguous wb_sel (e.g. 4'b0101) SHALL go to DONE with no SPI activity and rd_data=0.
REQ-021 Read, sel≠0, SHALL send frame = 0x03, then ADDR_BYTES address bytes, then N dummy bytes.
REQ-022 Write, sel≠0, SHALL send frame = 0x02, then address bytes, then N data bytes.
REQ-023 Read, sel=0, SHALL send 0x05 plus 1 dummy byte; the received byte goes to rd_data[7:0].
REQ-024 Write, sel=0, SHALL send 0x01 plus wr_data[7:0].
REQ-025 Every write SHALL first go through WREN: a one-byte 0x06 frame, then GAP with spi_ss high for CS_IDLE_CYCLES cycles, then FRAME.
REQ-026 Reads SHALL go from IDLE directly to FRAME.
REQ-027 SPI address SHALL be {address, first[1:0]}, zero-extended or truncated to ADDR_BYTES*8 bits, and sent MSB first.
REQ-028 Data bytes SHALL be sent in lane order first..last, lane k at address base+(k-first), each byte MSB first.
REQ-029 Received bytes SHALL land in rd_data[8k+:8]; unselected lanes read 0.
REQ-030 SPI mode 0: spi_sck idles low.
REQ-031 Each bit SHALL be CLOCK_DIVIDER cycles: sck low for the first half, high for the second half.
REQ-032 spi_mosi SHALL change only at the bit start.
REQ-033 spi_miso SHALL be sampled in the cycle sck rises.
REQ-034 A frame of B bytes SHALL hold spi_ss low for exactly 8*B*CLOCK_DIVIDER cycles.
REQ-035 spi_ss SHALL rise together with sck returning low.
REQ-036 DONE SHALL last one cycle, in which spi_ss=1; wb_ack=1 only if wb_cyc=1 in that cycle.
REQ-037 rd_data SHALL be valid in the ack cycle and hold until the next request is captured.
REQ-038 After DONE the block SHALL return to IDLE, and the CS_IDLE_CYCLES counter restarts.
REQ-039 wb_cyc is ignored in the ack cycle.
REQ-040 If wb_cyc drops mid-transaction, the SPI frame SHALL still complete; a request seen later starts a new transaction.
REQ-041 Byte and bit counters SHALL be sized for ADDR_BYTES+5 bytes with no wrap.

Reset
REQ-042 In the cycle after reset is high: state=IDLE, spi_ss=1, spi_sck=0, spi_mosi=0, wb_ack=0, busy=0, rd_data=0, idle counter expired.
REQ-043 Reset mid-frame SHALL abort immediately with no ack.

Verification
REQ-044 Read, sel=4'hF, address=0x000040, D=4, ADDR_BYTES=3, MISO model returns 11,22,33,44 -> MOSI shows 03 00 01 00; spi_ss low 256 cycles; ack at cycle 257; rd_data=0x44332211.
REQ-045 Write, sel=4'b0110, wr_data=0xAABBCCDD -> frame 06, then ss high 2 cycles, then 02 00 01 01 CC BB; one ack.
REQ-046 Read, sel=0 (status), MISO returns 0x82 -> MOSI shows 05; rd_data=0x00000082.
REQ-047 wb_sel=4'b1010 -> ack at cycle 1; no ss activity; rd_data=0.
REQ-048 Back-to-back reads with wb_cyc held high -> spi_ss high at least CS_IDLE_CYCLES+1 cycles between frames; exactly one ack per transaction.
REQ-049 Reset asserted at bit 20 of a write -> next cycle ss=1, sck=0, no ack; a following read completes normally.

Source files
------------

// File: rtl/spi_mem_wb_master.sv
// Wishbone word-access bridge onto an SPI serial memory (mode 0).
// Each request runs an optional WREN frame, then one read, write or status frame.

module spi_mem_wb_master #(
    parameter int unsigned ADDRESS_WIDTH  = 24,
    parameter int unsigned ADDR_BYTES     = 3,
    parameter int unsigned CLOCK_DIVIDER  = 4,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-3:0] address,
    input  logic [31:0]              wr_data,
    input  logic [3:0]               wb_sel,
    input  logic                     wb_we,
    input  logic                     wb_cyc,
    output logic [31:0]              rd_data,
    output logic                     wb_ack,
    output logic                     busy,
    input  logic                     spi_miso,
    output logic                     spi_sck,
    output logic                     spi_ss,
    output logic                     spi_mosi
);

    localparam int unsigned MaxBytes = ADDR_BYTES + 5;
    localparam int unsigned MaxBits  = MaxBytes * 8;
    localparam int unsigned AddrBits = ADDR_BYTES * 8;
    localparam int unsigned WideW    = (ADDRESS_WIDTH > AddrBits) ? ADDRESS_WIDTH : AddrBits;
    localparam int unsigned ByteW    = $clog2(MaxBytes + 1);
    localparam int unsigned PhaseW   = $clog2(CLOCK_DIVIDER);
    localparam int unsigned IdleW    = (CS_IDLE_CYCLES > 1) ? $clog2(CS_IDLE_CYCLES + 1) : 1;
    localparam int unsigned GapLoad  = (CS_IDLE_CYCLES > 0) ? CS_IDLE_CYCLES - 1 : 0;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StWren  = 3'd1;
    localparam logic [2:0] StGap   = 3'd2;
    localparam logic [2:0] StFrame = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    function automatic logic [1:0] lane_first(input logic [3:0] sel);
        lane_first = 2'd0;
        for (int k = 3; k >= 0; k--) if (sel[k]) lane_first = 2'(k);
    endfunction

    function automatic logic [1:0] lane_last(input logic [3:0] sel);
        lane_last = 2'd0;
        for (int k = 0; k < 4; k++) if (sel[k]) lane_last = 2'(k);
    endfunction

    function automatic logic lane_contig(input logic [3:0] sel);
        lane_contig = 1'b1;
        for (int k = 0; k < 4; k++)
            if (k >= int'(lane_first(sel)) && k <= int'(lane_last(sel)) && !sel[k])
                lane_contig = 1'b0;
    endfunction

    function automatic logic [ByteW-1:0] frame_bytes(input logic [3:0] sel);
        int n;
        n = int'(lane_last(sel)) - int'(lane_first(sel)) + 1;
        frame_bytes = (sel == 4'b0000) ? ByteW'(2) : ByteW'(1 + ADDR_BYTES + n);
    endfunction

    // Frame is left-aligned: the MSB of the vector is the first bit on the wire.
    function automatic logic [MaxBits-1:0] build_frame(input logic [ADDRESS_WIDTH-3:0] adr,
                                                       input logic [31:0] wdat,
                                                       input logic [3:0]  sel,
                                                       input logic        we);
        logic [WideW-1:0] wide;
        int first, last;
        build_frame = '0;
        first = int'(lane_first(sel));
        last  = int'(lane_last(sel));
        wide  = WideW'({adr, lane_first(sel)});
        if (sel == 4'b0000) begin
            build_frame[MaxBits-1 -: 8] = we ? 8'h01 : 8'h05;
            build_frame[MaxBits-9 -: 8] = we ? wdat[7:0] : 8'h00;
        end else begin
            build_frame[MaxBits-1 -: 8]        = we ? 8'h02 : 8'h03;
            build_frame[MaxBits-9 -: AddrBits] = wide[AddrBits-1:0];
            for (int k = 0; k < 4; k++)
                if (we && k >= first && k <= last)
                    build_frame[MaxBits-9-AddrBits-8*(k-first) -: 8] = wdat[8*k +: 8];
        end
    endfunction

    // The last received byte belongs to the highest lane.
    function automatic logic [31:0] assemble(input logic [31:0] rx, input logic [3:0] mask,
                                             input logic [1:0] last);
        assemble = '0;
        for (int k = 0; k < 4; k++)
            if (mask[k]) assemble[8*k +: 8] = rx[8*(int'(last)-k) +: 8];
    endfunction

    logic [2:0]               state_q, state_d;
    logic [PhaseW-1:0]        phase_q, phase_d;
    logic [2:0]               bit_q, bit_d;
    logic [ByteW-1:0]         byte_q, byte_d, nbytes_q, nbytes_d;
    logic [IdleW-1:0]         idle_q, idle_d;
    logic [MaxBits-1:0]       tx_q, tx_d;
    logic [31:0]              rx_q, rx_d, rd_q, rd_d, wdata_q, wdata_d;
    logic [ADDRESS_WIDTH-3:0] addr_q, addr_d;
    logic [3:0]               sel_q, sel_d, rmask_q, rmask_d;
    logic                     we_q, we_d;
    logic [1:0]               rlast_q, rlast_d;
    logic                     shifting, bit_end, frame_end;

    assign shifting  = (state_q == StWren) || (state_q == StFrame);
    assign bit_end   = phase_q == PhaseW'(CLOCK_DIVIDER - 1);
    assign frame_end = shifting && bit_end && bit_q == 3'd7 &&
                       byte_q == ((state_q == StWren) ? '0 : nbytes_q - ByteW'(1));

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        nbytes_d = nbytes_q;
        idle_d   = idle_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        we_d     = we_q;
        rmask_d  = rmask_q;
        rlast_d  = rlast_q;

        if (state_q == StFrame && phase_q == PhaseW'(CLOCK_DIVIDER / 2))
            rx_d = {rx_q[30:0], spi_miso};
        if (shifting) begin
            phase_d = bit_end ? '0 : phase_q + PhaseW'(1);
            if (bit_end) begin
                tx_d  = tx_q << 1;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) byte_d = byte_q + ByteW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (idle_q != '0) begin
                    idle_d = idle_q - IdleW'(1);
                end else if (wb_cyc) begin
                    addr_d   = address;
                    wdata_d  = wr_data;
                    sel_d    = wb_sel;
                    we_d     = wb_we;
                    rd_d     = '0;
                    nbytes_d = frame_bytes(wb_sel);
                    rmask_d  = wb_we ? 4'b0000 : ((wb_sel == 4'b0000) ? 4'b0001 : wb_sel);
                    rlast_d  = lane_last(wb_sel);
                    phase_d  = '0;
                    bit_d    = '0;
                    byte_d   = '0;
                    if (wb_sel != 4'b0000 && !lane_contig(wb_sel)) begin
                        state_d = StDone;
                    end else if (wb_we) begin
                        state_d = StWren;
                        tx_d    = {8'h06, {(MaxBits-8){1'b0}}};
                    end else begin
                        state_d = StFrame;
                        tx_d    = build_frame(address, wr_data, wb_sel, 1'b0);
                    end
                end
            end
            StWren: begin
                if (frame_end) begin
                    state_d = StGap;
                    idle_d  = IdleW'(GapLoad);
                    byte_d  = '0;
                end
            end
            StGap: begin
                if (idle_q == '0) begin
                    state_d = StFrame;
                    tx_d    = build_frame(addr_q, wdata_q, sel_q, we_q);
                end else begin
                    idle_d = idle_q - IdleW'(1);
                end
            end
            StFrame: begin
                if (frame_end) begin
                    state_d = StDone;
                    byte_d  = '0;
                    rd_d    = assemble(rx_d, rmask_q, rlast_q);
                end
            end
            StDone: begin
                state_d = StIdle;
                idle_d  = IdleW'(CS_IDLE_CYCLES);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            nbytes_q <= '0;
            idle_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rd_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            rmask_q  <= '0;
            rlast_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            nbytes_q <= nbytes_d;
            idle_q   <= idle_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            rmask_q  <= rmask_d;
            rlast_q  <= rlast_d;
        end
    end

    assign rd_data  = rd_q;
    assign busy     = state_q != StIdle;
    assign wb_ack   = (state_q == StDone) && wb_cyc;
    assign spi_ss   = !shifting;
    assign spi_sck  = shifting && (phase_q >= PhaseW'(CLOCK_DIVIDER / 2));
    assign spi_mosi = shifting && tx_q[MaxBits-1];

endmodule
